// File: rtl/int_gen_pkg.sv
// Shared encodings for the int_gen programmable interrupt source: FSM state
// codes, register indices, CTRL bit positions and the default acknowledge address.
package int_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_FIRE = 2'd3
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_MASK = 2;

    localparam logic [31:0] DEFAULT_ACK_ADDR = 32'h0000_7F20;

endpackage

// File: rtl/int_gen_regfile.sv
// CTRL/PERIOD storage, write decode and the combinational read mux for int_gen.
// COUNT and STATUS are owned by the top and only muxed onto Dout here.
module int_gen_regfile import int_gen_pkg::*; #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       reg_sel,
    input  logic             WE,
    input  logic [31:0]      Din,
    input  logic             en_clr,
    input  logic [CNT_W-1:0] count,
    input  logic [31:0]      status,
    output logic [31:0]      Dout,
    output logic             en,
    output logic             auto_rl,
    output logic             mask,
    output logic             en_nxt,
    output logic             auto_nxt,
    output logic [CNT_W-1:0] period
);

    logic        ctrl_wr;
    logic        mask_nxt;
    logic [31:0] period_ext;
    logic [31:0] count_ext;

    assign ctrl_wr = WE && (reg_sel == REG_CTRL);

    // A software CTRL write overrides the FSM's own EN clear on a non-auto ack.
    always_comb begin
        en_nxt   = ctrl_wr ? Din[CTRL_EN] : (en_clr ? 1'b0 : en);
        auto_nxt = ctrl_wr ? Din[CTRL_AUTO] : auto_rl;
        mask_nxt = ctrl_wr ? Din[CTRL_MASK] : mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en      <= 1'b0;
            auto_rl <= 1'b0;
            mask    <= 1'b0;
            period  <= '0;
        end else begin
            en      <= en_nxt;
            auto_rl <= auto_nxt;
            mask    <= mask_nxt;
            if (WE && (reg_sel == REG_PERIOD)) begin
                period <= Din[CNT_W-1:0];
            end
        end
    end

    always_comb begin
        period_ext              = '0;
        period_ext[CNT_W-1:0]   = period;
        count_ext               = '0;
        count_ext[CNT_W-1:0]    = count;
        case (reg_sel)
            REG_CTRL:   Dout = {29'd0, mask, auto_rl, en};
            REG_PERIOD: Dout = period_ext;
            REG_COUNT:  Dout = count_ext;
            default:    Dout = status;
        endcase
    end

endmodule

// File: rtl/int_gen.sv
// Programmable external interrupt source: IDLE/LOAD/CNT/FIRE countdown with bus ack.
// Build option INT_GEN_PULSE_EN turns the level interrupt into a one-cycle pulse.
module int_gen import int_gen_pkg::*; #(
    parameter logic [31:0] ACK_ADDR = DEFAULT_ACK_ADDR,
    parameter int          CNT_W    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    input  logic [31:0] m_int_addr,
    input  logic [3:0]  m_int_byteen,
    output logic        interrupt
);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] period;
    logic             pending;
    logic [15:0]      fire_cnt;
    logic             en, auto_rl, mask, en_nxt, auto_nxt;
    logic             ack, en_clr;
    logic [1:0]       state_code;
    logic [31:0]      status;
    logic [27:0]      unused_addr;

    assign unused_addr = Addr[29:2];
    assign ack         = (m_int_addr == ACK_ADDR) && (|m_int_byteen);
    assign en_clr      = (state == ST_FIRE) && en && ack && !auto_rl;
    assign state_code  = state;
    assign status      = {fire_cnt, 13'd0, state_code, pending};

    int_gen_regfile #(.CNT_W(CNT_W)) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .reg_sel  (Addr[1:0]),
        .WE       (WE),
        .Din      (Din),
        .en_clr   (en_clr),
        .count    (count),
        .status   (status),
        .Dout     (Dout),
        .en       (en),
        .auto_rl  (auto_rl),
        .mask     (mask),
        .en_nxt   (en_nxt),
        .auto_nxt (auto_nxt),
        .period   (period)
    );

`ifdef INT_GEN_PULSE_EN
    logic pulse;
    assign interrupt = pulse & ~mask;
`else
    assign interrupt = pending & ~mask;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            pending  <= 1'b0;
            fire_cnt <= '0;
`ifdef INT_GEN_PULSE_EN
            pulse    <= 1'b0;
`endif
        end else begin
`ifdef INT_GEN_PULSE_EN
            pulse <= 1'b0;
`endif
            if (ack) begin
                pending <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (en) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (period != '0) begin
                        count <= period;
                        state <= ST_CNT;
                    end
                end
                ST_CNT: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else begin
                        count <= count - 1'b1;
                        // A fresh fire wins over an ack landing on the same edge.
                        if (count == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            pending  <= 1'b1;
                            fire_cnt <= fire_cnt + 1'b1;
                            state    <= ST_FIRE;
`ifdef INT_GEN_PULSE_EN
                            pulse    <= 1'b1;
`endif
                        end
                    end
                end
                ST_FIRE: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (ack) begin
                        state <= (en_nxt && auto_nxt) ? ST_LOAD : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_gen.sv
// Directed, table-driven bench for int_gen: one table row per clock edge,
// followed by hand-written sequences for EN clear, reset and PERIOD=0 cases.
module tb_int_gen;

    localparam logic [1:0]  A_CTRL = 2'd0, A_PER = 2'd1, A_CNT = 2'd2, A_ST = 2'd3;
    localparam logic [31:0] ACK = 32'h0000_7F20;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [31:0] m_int_addr;
    logic [3:0]  m_int_byteen;
    logic        interrupt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [1:0]  wa;
        logic [31:0] wd;
        logic [31:0] aa;
        logic [3:0]  be;
        logic [1:0]  rs;
        logic [31:0] ed;
        logic        ei;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    int_gen dut (
        .clk          (clk),
        .reset        (reset),
        .Addr         (Addr),
        .WE           (WE),
        .Din          (Din),
        .Dout         (Dout),
        .m_int_addr   (m_int_addr),
        .m_int_byteen (m_int_byteen),
        .interrupt    (interrupt)
    );

    function automatic logic [31:0] st(input logic [15:0] fc, input logic [1:0] code, input logic p);
        return {fc, 13'd0, code, p};
    endfunction

    function automatic void v(input logic we, input logic [1:0] wa, input logic [31:0] wd,
                              input logic [31:0] aa, input logic [3:0] be,
                              input logic [1:0] rs, input logic [31:0] ed, input logic ei);
        vec_t r;
        r.we = we; r.wa = wa; r.wd = wd; r.aa = aa; r.be = be;
        r.rs = rs; r.ed = ed; r.ei = ei;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let one edge pass, then return bus to quiet.
    task automatic step(input logic we, input logic [1:0] wa, input logic [31:0] wd,
                        input logic [31:0] aa, input logic [3:0] be);
        WE = we; Addr = {28'd0, wa}; Din = wd; m_int_addr = aa; m_int_byteen = be;
        @(posedge clk);
        #1;
        WE = 1'b0; Din = '0; m_int_addr = '0; m_int_byteen = '0;
    endtask

    task automatic idle();
        step(1'b0, A_CTRL, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic rd(input string nm, input logic [1:0] rs, input logic [31:0] ed, input logic ei);
        Addr = {28'd0, rs};
        #1;
        chk({nm, "_dout"}, Dout, ed);
        chk({nm, "_int"}, {31'd0, interrupt}, {31'd0, ei});
    endtask

    initial begin
        bit found;
        reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0; m_int_addr = '0; m_int_byteen = '0;

        // Basic fire with PERIOD=5, rejected and accepted acks
        v(1, A_PER,  5,            0,       0, A_PER,  5,                   0);
        v(1, A_CTRL, 1,            0,       0, A_ST,   st(0, 0, 0),         0);
        v(0, 0,      0,            0,       0, A_ST,   st(0, 1, 0),         0);
        v(0, 0,      0,            0,       0, A_CNT,  5,                   0);
        v(0, 0,      0,            0,       0, A_CNT,  4,                   0);
        v(0, 0,      0,            0,       0, A_CNT,  3,                   0);
        v(0, 0,      0,            0,       0, A_CNT,  2,                   0);
        v(0, 0,      0,            0,       0, A_CNT,  1,                   0);
        v(0, 0,      0,            0,       0, A_ST,   32'h0001_0007,       1);
        v(0, 0,      0,            32'h7F24, 4'b0001, A_ST, 32'h0001_0007, 1);
        v(0, 0,      0,            ACK,     4'b0000, A_ST,  32'h0001_0007, 1);
        v(0, 0,      0,            ACK,     4'b0001, A_ST,  32'h0001_0000, 0);
        v(1, A_CNT,  32'h55,       0,       0, A_CNT,  0,                   0);
        v(1, A_CTRL, 32'hFFFF_FFF8, 0,      0, A_CTRL, 0,                   0);
        // AUTO reload, PERIOD=3
        v(1, A_PER,  3,            0,       0, A_PER,  3,                   0);
        v(1, A_CTRL, 3,            0,       0, A_CTRL, 3,                   0);
        v(0, 0,      0,            0,       0, A_ST,   st(1, 1, 0),         0);
        v(0, 0,      0,            0,       0, A_CNT,  3,                   0);
        v(0, 0,      0,            0,       0, A_CNT,  2,                   0);
        v(0, 0,      0,            0,       0, A_CNT,  1,                   0);
        v(0, 0,      0,            0,       0, A_ST,   st(2, 3, 1),         1);
        v(0, 0,      0,            ACK,     4'b1000, A_ST,  st(2, 1, 0),   0);
        v(0, 0,      0,            0,       0, A_CNT,  3,                   0);
        v(0, 0,      0,            0,       0, A_CNT,  2,                   0);
        v(0, 0,      0,            0,       0, A_CNT,  1,                   0);
        v(0, 0,      0,            0,       0, A_ST,   st(3, 3, 1),         1);
        v(1, A_CTRL, 0,            ACK,     4'b0100, A_ST,  st(3, 0, 0),   0);
        // MASK holds back the line but not PENDING
        v(1, A_PER,  2,            0,       0, A_PER,  2,                   0);
        v(1, A_CTRL, 5,            0,       0, A_CTRL, 5,                   0);
        v(0, 0,      0,            0,       0, A_ST,   st(3, 1, 0),         0);
        v(0, 0,      0,            0,       0, A_CNT,  2,                   0);
        v(0, 0,      0,            0,       0, A_CNT,  1,                   0);
        v(0, 0,      0,            0,       0, A_ST,   st(4, 3, 1),         0);
        v(1, A_CTRL, 1,            0,       0, A_ST,   st(4, 3, 1),         1);
        v(0, 0,      0,            ACK,     4'b0010, A_ST,  st(4, 0, 0),   0);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rd("rst_ctrl",   A_CTRL, 0, 0);
        rd("rst_period", A_PER,  0, 0);
        rd("rst_count",  A_CNT,  0, 0);
        rd("rst_status", A_ST,   0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].aa, tbl[i].be);
            rd($sformatf("vec%0d", i), tbl[i].rs, tbl[i].ed, tbl[i].ei);
        end

        // EN cleared mid-count: COUNT freezes one edge after the write edge
        step(1, A_PER, 10, 0, 0);
        step(1, A_CTRL, 1, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            Addr = {28'd0, A_CNT};
            #1;
            if (Dout == 32'd5) found = 1'b1;
            else idle();
        end
        chk("reach_cnt5", {31'd0, found}, 32'd1);
        step(1, A_CTRL, 0, 0, 0);
        idle();
        rd("stop_status", A_ST, st(4, 0, 0), 0);
        rd("stop_count", A_CNT, 4, 0);
        repeat (3) idle();
        rd("frozen_count", A_CNT, 4, 0);

        // Reset in the middle of a count
        step(1, A_CTRL, 1, 0, 0);
        repeat (4) idle();
        rd("pre_rst_st", A_ST, st(4, 2, 0), 0);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        rd("mid_rst_ctrl",   A_CTRL, 0, 0);
        rd("mid_rst_period", A_PER,  0, 0);
        rd("mid_rst_count",  A_CNT,  0, 0);
        rd("mid_rst_status", A_ST,   0, 0);

        // PERIOD=0 parks in LOAD; PERIOD=1 then fires two edges later
        step(1, A_CTRL, 1, 0, 0);
        repeat (20) idle();
        rd("p0_load", A_ST, st(0, 1, 0), 0);
        step(1, A_PER, 1, 0, 0);
        rd("p1_still_load", A_ST, st(0, 1, 0), 0);
        idle();
        rd("p1_count", A_CNT, 1, 0);
        idle();
        rd("p1_fire", A_ST, st(1, 3, 1), 1);

        // EN cleared while in FIRE keeps PENDING; ack in IDLE clears it
        step(1, A_CTRL, 0, 0, 0);
        rd("fire_enclr", A_ST, st(1, 3, 1), 1);
        idle();
        rd("fire_idle", A_ST, st(1, 0, 1), 1);
        step(0, A_CTRL, 0, ACK, 4'b1111);
        rd("idle_ack", A_ST, st(1, 0, 0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
